mem_port_arbiter: RTL and testbench

Round-robin arbiter that shares one main-memory port among `NUM_PORTS` cache hierarchies. Each port is the L2 miss/writeback interface of one hierarchy (`cachehier2mem_*` / `mem2cachehier_*`). The block grants one hierarchy at a time and forwards its request to memory. It routes the memory response back only to the granted hierarchy and holds the grant until that transaction has fully drained. It sits between the hierarchy instances and the main memory model / off-chip interface.

---
 rtl/mem_arb_pkg.sv | 27 ++
 rtl/rr_priority_picker.sv | 31 +++
 rtl/mem_port_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory-port arbiter: message encodings, FSM state type and
// the round-robin pointer advance helper.
package mem_arb_pkg;

  // Request encodings (cache hierarchy -> arbiter -> memory)
  localparam int unsigned NO_REQ = 0;
  localparam int unsigned R_REQ  = 1;
  localparam int unsigned WB_REQ = 2;
  localparam int unsigned FLUSH  = 3;

  // Response encodings (memory -> arbiter -> cache hierarchy)
  localparam int unsigned MEM_NO_MSG = 0;
  localparam int unsigned MEM_RESP   = 4;
  localparam int unsigned MEM_READY  = 5;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone,
    StDrain
  } arb_state_e;

  function automatic int unsigned next_port(input int unsigned idx, input int unsigned num_ports);
    return (idx + 1 >= num_ports) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first requester at or after ptr, modulo NUM_PORTS.
// Returns the winner as a one-hot vector and as a binary index.
module rr_priority_picker #(
  parameter int unsigned NUM_PORTS = 2,
  localparam int unsigned IdxW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IdxW-1:0]      ptr,
  output logic [NUM_PORTS-1:0] winner,
  output logic [IdxW-1:0]      winner_idx,
  output logic                 valid
);

  logic [IdxW-1:0] cand;

  always_comb begin
    winner     = '0;
    winner_idx = '0;
    valid      = 1'b0;
    cand       = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      cand = IdxW'((32'(ptr) + k) % NUM_PORTS);
      if (!valid && req[cand]) begin
        valid        = 1'b1;
        winner[cand] = 1'b1;
        winner_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one main-memory port among NUM_PORTS cache hierarchies.
// Optional watchdog enabled by defining MEM_PORT_ARB_WATCHDOG_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS      = 2,
  parameter int unsigned MSG_BITS       = 4,
  parameter int unsigned ADDRESS_BITS   = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned OFFSET_BITS    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  localparam int unsigned LINE_WIDTH    = DATA_WIDTH << OFFSET_BITS
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_PORTS*MSG_BITS-1:0]     port2arb_msg,
  input  logic [NUM_PORTS*ADDRESS_BITS-1:0] port2arb_address,
  input  logic [NUM_PORTS*LINE_WIDTH-1:0]   port2arb_data,
  output logic [NUM_PORTS*MSG_BITS-1:0]     arb2port_msg,
  output logic [NUM_PORTS*ADDRESS_BITS-1:0] arb2port_address,
  output logic [NUM_PORTS*LINE_WIDTH-1:0]   arb2port_data,
  output logic [MSG_BITS-1:0]               arb2mem_msg,
  output logic [ADDRESS_BITS-1:0]           arb2mem_address,
  output logic [LINE_WIDTH-1:0]             arb2mem_data,
  input  logic [MSG_BITS-1:0]               mem2arb_msg,
  input  logic [ADDRESS_BITS-1:0]           mem2arb_address,
  input  logic [LINE_WIDTH-1:0]             mem2arb_data,
  output logic [NUM_PORTS-1:0]              grant,
  output logic                              timeout
);

  localparam int unsigned IdxW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  localparam logic [MSG_BITS-1:0] MsgNoReq   = MSG_BITS'(NO_REQ);
  localparam logic [MSG_BITS-1:0] MsgNoMsg   = MSG_BITS'(MEM_NO_MSG);
  localparam logic [MSG_BITS-1:0] MsgResp    = MSG_BITS'(MEM_RESP);
  localparam logic [MSG_BITS-1:0] MsgReady   = MSG_BITS'(MEM_READY);

  if (NUM_PORTS < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("mem_port_arbiter: NUM_PORTS must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  logic [MSG_BITS-1:0]     req_msg  [NUM_PORTS];
  logic [ADDRESS_BITS-1:0] req_addr [NUM_PORTS];
  logic [LINE_WIDTH-1:0]   req_data [NUM_PORTS];
  logic [NUM_PORTS-1:0]    req_vec;

  logic [MSG_BITS-1:0]     resp_msg_q  [NUM_PORTS];
  logic [ADDRESS_BITS-1:0] resp_addr_q [NUM_PORTS];
  logic [LINE_WIDTH-1:0]   resp_data_q [NUM_PORTS];

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    assign req_msg[i]  = port2arb_msg[i*MSG_BITS +: MSG_BITS];
    assign req_addr[i] = port2arb_address[i*ADDRESS_BITS +: ADDRESS_BITS];
    assign req_data[i] = port2arb_data[i*LINE_WIDTH +: LINE_WIDTH];
    assign req_vec[i]  = (req_msg[i] != MsgNoReq);

    assign arb2port_msg[i*MSG_BITS +: MSG_BITS]             = resp_msg_q[i];
    assign arb2port_address[i*ADDRESS_BITS +: ADDRESS_BITS] = resp_addr_q[i];
    assign arb2port_data[i*LINE_WIDTH +: LINE_WIDTH]        = resp_data_q[i];
  end

  arb_state_e              state_q;
  logic [IdxW-1:0]         ptr_q;
  logic [IdxW-1:0]         gidx_q;
  logic [NUM_PORTS-1:0]    grant_q;
  logic [MSG_BITS-1:0]     mem_msg_q;
  logic [ADDRESS_BITS-1:0] mem_addr_q;
  logic [LINE_WIDTH-1:0]   mem_data_q;

  logic [NUM_PORTS-1:0] win_onehot;
  logic [IdxW-1:0]      win_idx;
  logic                 any_req;
  logic                 mem_has_resp;

  rr_priority_picker #(
    .NUM_PORTS (NUM_PORTS)
  ) u_picker (
    .req        (req_vec),
    .ptr        (ptr_q),
    .winner     (win_onehot),
    .winner_idx (win_idx),
    .valid      (any_req)
  );

  assign mem_has_resp = (mem2arb_msg == MsgResp) || (mem2arb_msg == MsgReady);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      gidx_q      <= '0;
      grant_q     <= '0;
      mem_msg_q   <= MsgNoReq;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      resp_msg_q  <= '{default: '0};
      resp_addr_q <= '{default: '0};
      resp_data_q <= '{default: '0};
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            gidx_q     <= win_idx;
            grant_q    <= win_onehot;
            mem_msg_q  <= req_msg[win_idx];
            mem_addr_q <= req_addr[win_idx];
            mem_data_q <= req_data[win_idx];
            state_q    <= StBusy;
          end
        end
        StBusy: begin
          // A granted port dropping early is forwarded as-is; its response still lands.
          mem_msg_q  <= req_msg[gidx_q];
          mem_addr_q <= req_addr[gidx_q];
          mem_data_q <= req_data[gidx_q];
          if (mem_has_resp) begin
            resp_msg_q[gidx_q]  <= mem2arb_msg;
            resp_addr_q[gidx_q] <= mem2arb_address;
            resp_data_q[gidx_q] <= mem2arb_data;
            state_q             <= StDone;
          end
        end
        StDone: begin
          mem_msg_q  <= req_msg[gidx_q];
          mem_addr_q <= req_addr[gidx_q];
          mem_data_q <= req_data[gidx_q];
          if (req_msg[gidx_q] == MsgNoReq) begin
            resp_msg_q[gidx_q] <= MsgNoReq;
            ptr_q              <= IdxW'(next_port(32'(gidx_q), NUM_PORTS));
            state_q            <= StDrain;
          end
        end
        StDrain: begin
          // Hold grant until memory has retracted its response, so it cannot leak to the
          // next owner.
          if (mem2arb_msg == MsgNoMsg) begin
            grant_q     <= '0;
            mem_msg_q   <= MsgNoReq;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            resp_msg_q  <= '{default: '0};
            resp_addr_q <= '{default: '0};
            resp_data_q <= '{default: '0};
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign grant           = grant_q;
  assign arb2mem_msg     = mem_msg_q;
  assign arb2mem_address = mem_addr_q;
  assign arb2mem_data    = mem_data_q;

`ifdef MEM_PORT_ARB_WATCHDOG_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] wd_cnt_q;
  logic            timeout_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else if (state_q == StIdle && any_req) begin
      wd_cnt_q <= '0;
    end else if (state_q == StBusy && wd_cnt_q != CntW'(TIMEOUT_CYCLES)) begin
      wd_cnt_q <= wd_cnt_q + CntW'(1);
      if (wd_cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a transaction-level
// reference model compared against the DUT on every falling clock edge.
module tb_mem_port_arbiter;

  localparam int NP = 2;
  localparam int MB = 4;
  localparam int AB = 32;
  localparam int DW = 32;
  localparam int OB = 2;
  localparam int LW = DW << OB;
  localparam int TO = 16;

  localparam logic [127:0] LINE_A  = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [127:0] LINE_WB = 128'hDEADBEEF_CAFEF00D_0BADF00D_12345678;
  localparam logic [127:0] LINE_C  = 128'h55AA55AA_00FF00FF_13579BDF_2468ACE0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [NP*MB-1:0] p_msg  = '0;
  logic [NP*AB-1:0] p_addr = '0;
  logic [NP*LW-1:0] p_data = '0;
  logic [NP*MB-1:0] r_msg;
  logic [NP*AB-1:0] r_addr;
  logic [NP*LW-1:0] r_data;
  logic [MB-1:0]    am_msg;
  logic [AB-1:0]    am_addr;
  logic [LW-1:0]    am_data;
  logic [MB-1:0]    m_msg  = '0;
  logic [AB-1:0]    m_addr = '0;
  logic [LW-1:0]    m_data = '0;
  logic [NP-1:0]    grant;
  logic             timeout;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .NUM_PORTS      (NP),
    .MSG_BITS       (MB),
    .ADDRESS_BITS   (AB),
    .DATA_WIDTH     (DW),
    .OFFSET_BITS    (OB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock            (clk),
    .reset            (rst_n),
    .port2arb_msg     (p_msg),
    .port2arb_address (p_addr),
    .port2arb_data    (p_data),
    .arb2port_msg     (r_msg),
    .arb2port_address (r_addr),
    .arb2port_data    (r_data),
    .arb2mem_msg      (am_msg),
    .arb2mem_address  (am_addr),
    .arb2mem_data     (am_data),
    .mem2arb_msg      (m_msg),
    .mem2arb_address  (m_addr),
    .mem2arb_data     (m_data),
    .grant            (grant),
    .timeout          (timeout)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [MB-1:0] pmsg(input int i);
    return p_msg[i*MB +: MB];
  endfunction

  // ---------------- reference model (transaction level) ----------------
  int           owner = -1;  // port holding the memory, -1 when none
  bit           have_resp = 1'b0;
  bit           released = 1'b0;
  int           ptr = 0;
  int           busy_cnt = 0;
  bit           exp_to = 1'b0;
  int           cand;
  logic [MB-1:0] f_msg = '0;
  logic [AB-1:0] f_addr = '0;
  logic [LW-1:0] f_data = '0;
  logic [MB-1:0] s_msg = '0;
  logic [AB-1:0] s_addr = '0;
  logic [LW-1:0] s_data = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner = -1; have_resp = 0; released = 0; ptr = 0; busy_cnt = 0; exp_to = 0;
    end else if (owner < 0) begin
      for (int k = 0; k < NP; k++) begin
        cand = (ptr + k) % NP;
        if (owner < 0 && pmsg(cand) != 0) owner = cand;
      end
      if (owner >= 0) begin
        have_resp = 0; released = 0; busy_cnt = 0;
        f_msg = pmsg(owner); f_addr = p_addr[owner*AB +: AB]; f_data = p_data[owner*LW +: LW];
      end
    end else if (!have_resp) begin
      busy_cnt++;
`ifdef MEM_PORT_ARB_WATCHDOG_EN
      if (busy_cnt >= TO) exp_to = 1'b1;
`endif
      f_msg = pmsg(owner); f_addr = p_addr[owner*AB +: AB]; f_data = p_data[owner*LW +: LW];
      if (m_msg == 4 || m_msg == 5) begin
        have_resp = 1; s_msg = m_msg; s_addr = m_addr; s_data = m_data;
      end
    end else if (!released) begin
      f_msg = pmsg(owner); f_addr = p_addr[owner*AB +: AB]; f_data = p_data[owner*LW +: LW];
      if (pmsg(owner) == 0) begin
        released = 1;
        ptr = (owner + 1) % NP;
      end
    end else if (m_msg == 0) begin
      owner = -1; have_resp = 0; released = 0;
    end
  end

  function automatic logic [NP-1:0] exp_grant();
    return (owner >= 0) ? NP'(1) << owner : '0;
  endfunction

  function automatic logic [MB-1:0] exp_mem_msg();
    return (owner >= 0 && !released) ? f_msg : '0;
  endfunction

  function automatic logic [MB-1:0] exp_port_msg(input int i);
    return (i == owner && have_resp && !released) ? s_msg : '0;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("grant", grant, exp_grant());
      check("mem_msg", am_msg, exp_mem_msg());
      if (exp_mem_msg() != 0) begin
        check("mem_addr", am_addr, f_addr);
        check("mem_data", am_data, f_data);
      end
      for (int i = 0; i < NP; i++) begin
        check($sformatf("port%0d_msg", i), r_msg[i*MB +: MB], exp_port_msg(i));
        if (exp_port_msg(i) != 0) begin
          check($sformatf("port%0d_addr", i), r_addr[i*AB +: AB], s_addr);
          check($sformatf("port%0d_data", i), r_data[i*LW +: LW], s_data);
        end else if (i != owner) begin
          check($sformatf("port%0d_idle_addr", i), r_addr[i*AB +: AB], 0);
          check($sformatf("port%0d_idle_data", i), r_data[i*LW +: LW], 0);
        end
      end
      check("timeout", timeout, exp_to);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_port(input int i, input logic [MB-1:0] msg, input logic [AB-1:0] addr,
                          input logic [LW-1:0] data);
    p_msg[i*MB +: MB]  = msg;
    p_addr[i*AB +: AB] = addr;
    p_data[i*LW +: LW] = data;
  endtask

  task automatic set_mem(input logic [MB-1:0] msg, input logic [AB-1:0] addr,
                         input logic [LW-1:0] data);
    m_msg = msg; m_addr = addr; m_data = data;
  endtask

  task automatic wait_grant(input int budget, output logic [NP-1:0] g);
    int n = 0;
    while (grant == 0 && n < budget) begin
      tick();
      n++;
    end
    g = grant;
    if (grant == 0) begin
      errors++;
      checks++;
      $display("FAIL wait_grant actual=0 required=nonzero within %0d cycles", budget);
    end
  endtask

  // Assumes the DUT is in its first BUSY cycle for port g; returns in the following IDLE cycle.
  task automatic serve(input int g);
    tick();
    set_mem(4'd4, 32'h0, LINE_C);
    tick();
    set_port(g, 4'd0, 32'h0, '0);
    tick();
    set_mem(4'd0, 32'h0, '0);
    tick();
  endtask

  // ---------------- directed scenarios ----------------
  logic [NP-1:0] g;
  logic [NP-1:0] fair_exp [5];

  initial begin
    fair_exp = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
    repeat (3) @(posedge clk);
    #2;
    chk_en = 1'b1;
    check("reset_grant", grant, 0);
    check("reset_mem_msg", am_msg, 0);
    check("reset_port_msg", r_msg, 0);
    check("reset_timeout", timeout, 0);
    rst_n = 1'b1;
    tick();

    // Fairness: both ports request continuously, grant alternates with an idle gap.
    set_port(0, 4'd1, 32'h1000, '0);
    set_port(1, 4'd1, 32'h2000, '0);
    for (int n = 0; n < 5; n++) begin
      wait_grant(4, g);
      check($sformatf("fair_order%0d", n), g, fair_exp[n]);
      serve(g[1] ? 1 : 0);
      check($sformatf("fair_gap%0d", n), grant, 0);
      if (n < 3) set_port(g[1] ? 1 : 0, 4'd1, g[1] ? 32'h2000 : 32'h1000, '0);
    end
    tick();

    // Single request on port 0.
    set_port(0, 4'd1, 32'h100, '0);
    tick();
    check("s1_grant", grant, 2'b01);
    check("s1_mem_msg", am_msg, 4'd1);
    check("s1_mem_addr", am_addr, 32'h100);
    set_mem(4'd4, 32'h100, LINE_A);
    tick();
    check("s1_port0_msg", r_msg[3:0], 4'd4);
    check("s1_port0_data", r_data[LW-1:0], LINE_A);
    check("s1_port1_msg", r_msg[7:4], 4'd0);
    tick();
    check("s1_hold", r_msg[3:0], 4'd4);
    set_port(0, 4'd0, 32'h0, '0);
    tick();
    check("s1_release_mem", am_msg, 4'd0);
    check("s1_release_port", r_msg[3:0], 4'd0);
    check("s1_drain_grant", grant, 2'b01);
    tick();
    check("s1_drain_wait", grant, 2'b01);
    set_mem(4'd0, 32'h0, '0);
    tick();
    check("s1_idle", grant, 2'b00);

    // Writeback from port 1.
    set_port(1, 4'd2, 32'h240, LINE_WB);
    tick();
    check("wb_grant", grant, 2'b10);
    check("wb_mem_msg", am_msg, 4'd2);
    check("wb_mem_addr", am_addr, 32'h240);
    check("wb_mem_data", am_data, LINE_WB);
    set_mem(4'd5, 32'h240, '0);
    tick();
    check("wb_port1_ready", r_msg[7:4], 4'd5);
    check("wb_port0_quiet", r_msg[3:0], 4'd0);
    set_port(1, 4'd0, 32'h0, '0);
    tick();
    set_mem(4'd0, 32'h0, '0);
    tick();
    check("wb_idle", grant, 2'b00);

    // Memory drops its response early; port 0 keeps seeing it until it releases.
    set_port(0, 4'd1, 32'h300, '0);
    tick();
    set_mem(4'd4, 32'h300, LINE_C);
    tick();
    set_mem(4'd0, 32'h0, '0);
    for (int n = 0; n < 5; n++) begin
      tick();
      check($sformatf("early_hold%0d", n), r_msg[3:0], 4'd4);
    end
    set_port(0, 4'd0, 32'h0, '0);
    tick();
    check("early_release", r_msg[3:0], 4'd0);
    tick();
    check("early_idle", grant, 2'b00);

    // Reset while BUSY, then both request: the pointer must be back at 0.
    set_port(1, 4'd1, 32'h500, '0);
    tick();
    check("rst_busy_grant", grant, 2'b10);
    rst_n = 1'b0;
    #1;
    check("rst_async_grant", grant, 0);
    check("rst_async_mem_msg", am_msg, 0);
    check("rst_async_port_msg", r_msg, 0);
    set_port(0, 4'd1, 32'h400, '0);
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_ptr_zero", grant, 2'b01);

    // Watchdog: memory stays silent while port 0 is granted.
    repeat (5) tick();
    check("wd_early", timeout, 1'b0);
    repeat (20) tick();
`ifdef MEM_PORT_ARB_WATCHDOG_EN
    check("wd_fired", timeout, 1'b1);
`else
    check("wd_absent", timeout, 1'b0);
`endif
    rst_n = 1'b0;
    #1;
    check("wd_reset", timeout, 1'b0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit actual=running required=finished");
    $fatal(1);
  end

endmodule
